// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator: divides clk to the sample rate and advances the phase by a double-buffered FCW on each tick.
// One cycle tick-to-output; fcw_ready stays low while a word is pending, until the next tick consumes it.
module nco_phase_accumulator #(
  parameter int SAMPLE_DIV = 2500,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACC_WIDTH-1:0] fcw_data,
  input  logic                 fcw_valid,
  output logic                 fcw_ready,
  input  logic                 note_start,
  input  logic                 note_release,
  output logic [ACC_WIDTH-1:0] accumulated_value,
  output logic                 sample_valid,
  output logic                 playing
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] fcw_pending_q, fcw_pending_d;
  logic [ACC_WIDTH-1:0] fcw_active_q, fcw_active_d;
  logic                 pending_full_q, pending_full_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 playing_q, playing_d;

  logic                 tick;
  logic                 fcw_accept;
  logic [ACC_WIDTH:0]   sum;
  logic                 stop_now;

  assign tick       = (div_cnt_q == DIV_LAST);
  assign fcw_ready  = !pending_full_q;
  assign fcw_accept = fcw_valid && !pending_full_q;
  assign sum        = {1'b0, acc_q} + {1'b0, fcw_active_q};
  // A stopping note ends at the phase wrap, or at once if it can never wrap.
  assign stop_now   = sum[ACC_WIDTH] || (fcw_active_q == '0);

  assign accumulated_value = acc_q;
  assign sample_valid      = sample_valid_q;
  assign playing           = playing_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      div_cnt_q      <= '0;
      acc_q          <= '0;
      fcw_pending_q  <= '0;
      fcw_active_q   <= '0;
      pending_full_q <= 1'b0;
      sample_valid_q <= 1'b0;
      playing_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      acc_q          <= acc_d;
      fcw_pending_q  <= fcw_pending_d;
      fcw_active_q   <= fcw_active_d;
      pending_full_q <= pending_full_d;
      sample_valid_q <= sample_valid_d;
      playing_q      <= playing_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (note_start && !note_release) state_d = PLAY;
      end
      PLAY: begin
        if (note_release) state_d = STOPPING;
      end
      STOPPING: begin
        if (note_release)          state_d = STOPPING;
        else if (note_start)       state_d = PLAY;
        else if (tick && stop_now) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    playing_d      = (state_d != IDLE);
    sample_valid_d = tick;
  end

  always_comb begin
    div_cnt_d      = tick ? '0 : div_cnt_q + DIV_W'(1);
    fcw_pending_d  = fcw_pending_q;
    pending_full_d = pending_full_q;
    fcw_active_d   = fcw_active_q;
    acc_d          = acc_q;

    // Accept and consume are exclusive: accept needs the pending slot empty.
    if (fcw_accept) begin
      fcw_pending_d  = fcw_data;
      pending_full_d = 1'b1;
    end else if (tick && pending_full_q) begin
      fcw_active_d   = fcw_pending_q;
      pending_full_d = 1'b0;
    end

    if (tick) begin
      unique case (state_q)
        PLAY:     acc_d = sum[ACC_WIDTH-1:0];
        STOPPING: acc_d = stop_now ? '0 : sum[ACC_WIDTH-1:0];
        default:  acc_d = '0;
      endcase
    end
  end

endmodule
